// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, derived totals and the control bundle
// carried down the pixel-alignment delay line.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Counters are never narrower than the 10-bit oX/oY coordinates.
    function automatic int cnt_width(input int total);
        int w;
        w = $clog2(total);
        return (w < 10) ? 10 : w;
    endfunction

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value.
// o_pre exposes the stage just before the output for look-ahead gating.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_pre
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[DEPTH-1];

    generate
        if (DEPTH > 1) begin : g_pre_stage
            assign o_pre = r_stage[DEPTH-2];
        end else begin : g_pre_input
            assign o_pre = i_data;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: issues pixel requests REQ_LEAD clocks ahead of the source
// data and re-aligns sync/blank with the registered colour outputs.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 8,
    parameter int REQ_LEAD = 2
) (
    input  logic          iCLK25,
    input  logic          iRST_N,
    input  logic [CW-1:0] iVGA_R,
    input  logic [CW-1:0] iVGA_G,
    input  logic [CW-1:0] iVGA_B,
    output logic [CW-1:0] oVGA_R,
    output logic [CW-1:0] oVGA_G,
    output logic [CW-1:0] oVGA_B,
    output logic          oVGA_H_SYNC,
    output logic          oVGA_V_SYNC,
    output logic          oVGA_BLANK_N,
    output logic          oPSAVE_N,
    output logic          oVGA_CLK,
    output logic          oRequest,
    output logic [9:0]    oX,
    output logic [9:0]    oY,
    output logic          oFrameStart
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = cnt_width(H_TOTAL);
    localparam int VW        = cnt_width(V_TOTAL);
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

    localparam vga_ctl_t CTL_RST = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_visible;
    logic          w_hs_win;
    logic          w_vs_win;

    logic          r_req;
    logic          r_fs;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    vga_ctl_t      r_ctl;
    vga_ctl_t      w_ctl_out;
    vga_ctl_t      w_ctl_pre;
    logic [CW-1:0] r_r;
    logic [CW-1:0] r_g;
    logic [CW-1:0] r_b;

    assign w_h_last  = (r_hcnt == HW'(H_TOTAL - 1));
    assign w_v_last  = (r_vcnt == VW'(V_TOTAL - 1));
    assign w_visible = (r_hcnt < HW'(H_ACTIVE)) && (r_vcnt < VW'(V_ACTIVE));
    assign w_hs_win  = (r_hcnt >= HW'(H_SYNC_LO)) && (r_hcnt < HW'(H_SYNC_HI));
    // vcnt only moves on the hcnt wrap, so vertical sync edges land on hcnt=0.
    assign w_vs_win  = (r_vcnt >= VW'(V_SYNC_LO)) && (r_vcnt < VW'(V_SYNC_HI));

    always_ff @(posedge iCLK25 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Request stage: outputs describe the counter position sampled at this edge,
    // so pixel (0,0) is requested on the very first clock after reset.
    always_ff @(posedge iCLK25 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_req <= 1'b0;
            r_fs  <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_ctl <= CTL_RST;
        end else begin
            r_req         <= w_visible;
            r_fs          <= (r_hcnt == '0) && (r_vcnt == '0);
            r_ctl.hs      <= w_hs_win ? HS_POL : ~HS_POL;
            r_ctl.vs      <= w_vs_win ? VS_POL : ~VS_POL;
            r_ctl.blank_n <= w_visible;
            if (w_visible) begin
                r_x <= 10'(r_hcnt);
                r_y <= 10'(r_vcnt);
            end
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (REQ_LEAD + 1),
        .RST_VAL (CTL_RST)
    ) u_ctl_dly (
        .i_clk   (iCLK25),
        .i_rst_n (iRST_N),
        .i_data  (r_ctl),
        .o_data  (w_ctl_out),
        .o_pre   (w_ctl_pre)
    );

    // w_ctl_pre is the blank_n that reaches the output on the same edge as this data.
    always_ff @(posedge iCLK25 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (w_ctl_pre.blank_n) begin
            r_r <= iVGA_R;
            r_g <= iVGA_G;
            r_b <= iVGA_B;
        end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end
    end

    assign oVGA_R       = r_r;
    assign oVGA_G       = r_g;
    assign oVGA_B       = r_b;
    assign oVGA_H_SYNC  = w_ctl_out.hs;
    assign oVGA_V_SYNC  = w_ctl_out.vs;
    assign oVGA_BLANK_N = w_ctl_out.blank_n;
    assign oPSAVE_N     = 1'b1;
    assign oVGA_CLK     = iCLK25;
    assign oRequest     = r_req;
    assign oX           = r_x;
    assign oY           = r_y;
    assign oFrameStart  = r_fs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: small-raster instances (both sync polarities) and
// one default 640x480 instance, checked cycle by cycle against a raster model.
module tb_vga_timing_ctrl;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FR = S_HT * S_VT;
    localparam int LEAD = 2;
    localparam int PIPE = LEAD + 1;
    localparam int CW   = 8;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] src_r, src_g, src_b;
    logic [CW-1:0] zero_px;

    logic [CW-1:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic          a_hs, a_vs, a_bn, a_ps, a_ck, a_req, a_fs;
    logic          b_hs, b_vs, b_bn, b_ps, b_ck, b_req, b_fs;
    logic          c_hs, c_vs, c_bn, c_ps, c_ck, c_req, c_fs;
    logic [9:0]    a_x, a_y, b_x, b_y, c_x, c_y;

    int            n_checks;
    int            n_fail;
    int            cyc;
    logic [CW-1:0] src_q[$];

    vga_timing_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .REQ_LEAD(LEAD)
    ) u_dut_a (
        .iCLK25(clk), .iRST_N(rst_n),
        .iVGA_R(src_r), .iVGA_G(src_g), .iVGA_B(src_b),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
        .oVGA_H_SYNC(a_hs), .oVGA_V_SYNC(a_vs), .oVGA_BLANK_N(a_bn),
        .oPSAVE_N(a_ps), .oVGA_CLK(a_ck), .oRequest(a_req),
        .oX(a_x), .oY(a_y), .oFrameStart(a_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .REQ_LEAD(LEAD)
    ) u_dut_b (
        .iCLK25(clk), .iRST_N(rst_n),
        .iVGA_R(src_r), .iVGA_G(src_g), .iVGA_B(src_b),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
        .oVGA_H_SYNC(b_hs), .oVGA_V_SYNC(b_vs), .oVGA_BLANK_N(b_bn),
        .oPSAVE_N(b_ps), .oVGA_CLK(b_ck), .oRequest(b_req),
        .oX(b_x), .oY(b_y), .oFrameStart(b_fs)
    );

    vga_timing_ctrl u_dut_c (
        .iCLK25(clk), .iRST_N(rst_n),
        .iVGA_R(zero_px), .iVGA_G(zero_px), .iVGA_B(zero_px),
        .oVGA_R(c_r), .oVGA_G(c_g), .oVGA_B(c_b),
        .oVGA_H_SYNC(c_hs), .oVGA_V_SYNC(c_vs), .oVGA_BLANK_N(c_bn),
        .oPSAVE_N(c_ps), .oVGA_CLK(c_ck), .oRequest(c_req),
        .oX(c_x), .oY(c_y), .oFrameStart(c_fs)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raster model: p is a pixel-clock position inside one small frame.
    function automatic bit vis(input int p);
        return ((p % S_HT) < S_HA) && ((p / S_HT) < S_VA);
    endfunction

    function automatic bit hs_win(input int p);
        return ((p % S_HT) >= S_HA + S_HF) && ((p % S_HT) < S_HA + S_HF + S_HS);
    endfunction

    function automatic bit vs_win(input int p);
        return ((p / S_HT) >= S_VA + S_VF) && ((p / S_HT) < S_VA + S_VF + S_VS);
    endfunction

    function automatic int pix_idx(input int p);
        return (p / S_HT) * S_HA + (p % S_HT);
    endfunction

    // Drivers
    task automatic do_release();
        rst_n = 1'b0;
        src_q.delete();
        src_r = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = -1;
        src_g = CW'($urandom_range(0, 255));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pixel source with LEAD clocks of latency, returning the raster index it was asked for.
    task automatic drive_src();
        src_q.push_back(CW'(int'(a_y) * S_HA + int'(a_x)));
        if (src_q.size() > LEAD) src_r = src_q.pop_front();
        src_g = CW'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_req, a_fs, a_bn, a_hs, a_vs} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_ctl_a got=%b exp=00011", {a_req, a_fs, a_bn, a_hs, a_vs});
        end
        n_checks++;
        if ({a_x, a_y} !== 20'd0 || {a_r, a_g, a_b} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_data_a xy=%h rgb=%h exp=0", {a_x, a_y}, {a_r, a_g, a_b});
        end
        n_checks++;
        if ({b_hs, b_vs, b_bn} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pol1_b got=%b exp=000", {b_hs, b_vs, b_bn});
        end
        n_checks++;
        if ({c_hs, c_vs, c_ps, c_req} !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_default_c got=%b exp=1110", {c_hs, c_vs, c_ps, c_req});
        end
    endtask

    task automatic test_raster();
        int p;
        int reqs;
        int last_fs;
        bit exp_req;
        do_release();
        reqs    = 0;
        last_fs = -1;
        for (int i = 0; i < 2 * S_FR; i++) begin
            step();
            p       = cyc % S_FR;
            exp_req = vis(p);
            n_checks++;
            if (a_req !== exp_req) begin
                n_fail++;
                $display("FAIL raster_req cyc=%0d got=%b exp=%b", cyc, a_req, exp_req);
            end
            if (exp_req) begin
                reqs++;
                n_checks++;
                if (a_x !== 10'(p % S_HT) || a_y !== 10'(p / S_HT)) begin
                    n_fail++;
                    $display("FAIL raster_xy cyc=%0d got=%0d,%0d exp=%0d,%0d",
                             cyc, a_x, a_y, p % S_HT, p / S_HT);
                end
            end
            n_checks++;
            if (a_fs !== (p == 0)) begin
                n_fail++;
                $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, a_fs, p == 0);
            end
            if (a_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (cyc - last_fs != S_FR) begin
                        n_fail++;
                        $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, S_FR);
                    end
                end
                last_fs = cyc;
            end
            if (p == S_FR - 1) begin
                n_checks++;
                if (reqs != S_HA * S_VA) begin
                    n_fail++;
                    $display("FAIL req_per_frame got=%0d exp=%0d", reqs, S_HA * S_VA);
                end
                reqs = 0;
            end
            drive_src();
        end
    endtask

    task automatic test_pixel_data();
        int q;
        bit exp_bn;
        logic [CW-1:0] exp_r, exp_g, exp_b;
        do_release();
        for (int i = 0; i < 2 * S_FR + PIPE; i++) begin
            step();
            q      = (cyc - PIPE) % S_FR;
            exp_bn = (cyc >= PIPE) && vis(q);
            exp_r  = exp_bn ? CW'(pix_idx(q)) : '0;
            exp_g  = exp_bn ? src_g : '0;
            exp_b  = exp_bn ? {CW{1'b1}} : '0;
            n_checks++;
            if (a_bn !== exp_bn) begin
                n_fail++;
                $display("FAIL blank_n cyc=%0d got=%b exp=%b", cyc, a_bn, exp_bn);
            end
            n_checks++;
            if ({a_r, a_g, a_b} !== {exp_r, exp_g, exp_b}) begin
                n_fail++;
                $display("FAIL pixel_rgb cyc=%0d got=%h exp=%h", cyc,
                         {a_r, a_g, a_b}, {exp_r, exp_g, exp_b});
            end
            drive_src();
        end
    endtask

    task automatic test_sync_pol();
        int q;
        int vs_low;
        bit hw, vw;
        do_release();
        vs_low = 0;
        for (int i = 0; i < 2 * S_FR + PIPE; i++) begin
            step();
            q  = (cyc - PIPE) % S_FR;
            hw = (cyc >= PIPE) && hs_win(q);
            vw = (cyc >= PIPE) && vs_win(q);
            n_checks++;
            if ({a_hs, a_vs} !== {~hw, ~vw}) begin
                n_fail++;
                $display("FAIL sync_pol0 cyc=%0d got=%b exp=%b", cyc, {a_hs, a_vs}, {~hw, ~vw});
            end
            n_checks++;
            if ({b_hs, b_vs} !== {hw, vw}) begin
                n_fail++;
                $display("FAIL sync_pol1 cyc=%0d got=%b exp=%b", cyc, {b_hs, b_vs}, {hw, vw});
            end
            if (a_vs === 1'b0) begin
                vs_low++;
            end else if (vs_low != 0) begin
                n_checks++;
                if (vs_low != S_VS * S_HT) begin
                    n_fail++;
                    $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * S_HT);
                end
                vs_low = 0;
            end
            drive_src();
        end
    endtask

    task automatic test_default_hsync();
        int q;
        int low_run;
        int last_fall;
        bit prev_hs;
        bit exp_hs;
        do_release();
        low_run   = 0;
        last_fall = -1;
        prev_hs   = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            step();
            q      = (cyc - PIPE) % 800;
            exp_hs = !((cyc >= PIPE) && q >= 656 && q < 752);
            n_checks++;
            if (c_hs !== exp_hs || c_vs !== 1'b1) begin
                n_fail++;
                $display("FAIL default_sync cyc=%0d got=%b%b exp=%b1", cyc, c_hs, c_vs, exp_hs);
            end
            if (prev_hs && c_hs === 1'b0) begin
                if (last_fall >= 0) begin
                    n_checks++;
                    if (cyc - last_fall != 800) begin
                        n_fail++;
                        $display("FAIL hsync_period got=%0d exp=800", cyc - last_fall);
                    end
                end
                last_fall = cyc;
            end
            if (c_hs === 1'b0) begin
                low_run++;
            end else if (low_run != 0) begin
                n_checks++;
                if (low_run != 96) begin
                    n_fail++;
                    $display("FAIL hsync_width got=%0d exp=96", low_run);
                end
                low_run = 0;
            end
            prev_hs = c_hs;
        end
        n_checks++;
        if (last_fall != PIPE + 656 + 1600) begin
            n_fail++;
            $display("FAIL hsync_last_fall got=%0d exp=%0d", last_fall, PIPE + 656 + 1600);
        end
    endtask

    task automatic test_mid_reset();
        int q;
        bit exp_bn;
        do_release();
        while (cyc < 3 * S_HT + 5) begin
            step();
            drive_src();
        end
        n_checks++;
        if (a_req !== 1'b1 || a_x !== 10'd5 || a_y !== 10'd3) begin
            n_fail++;
            $display("FAIL midrst_pre got=%b %0d,%0d exp=1 5,3", a_req, a_x, a_y);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_req, a_fs, a_bn, a_hs, a_vs, b_hs, b_vs} !== 7'b0001100 ||
            {a_x, a_y, a_r, a_g, a_b} !== 44'd0) begin
            n_fail++;
            $display("FAIL midrst_async got=%b xy=%h rgb=%h exp=0001100 0 0",
                     {a_req, a_fs, a_bn, a_hs, a_vs, b_hs, b_vs}, {a_x, a_y}, {a_r, a_g, a_b});
        end
        repeat (3) @(posedge clk);
        #1;
        src_q.delete();
        rst_n = 1'b1;
        cyc   = -1;
        for (int i = 0; i < S_HT + PIPE; i++) begin
            step();
            q      = cyc - PIPE;
            exp_bn = (cyc >= PIPE) && vis(q);
            n_checks++;
            if ({a_fs, a_req, a_bn} !== {cyc == 0, vis(cyc), exp_bn}) begin
                n_fail++;
                $display("FAIL midrst_restart cyc=%0d got=%b exp=%b", cyc,
                         {a_fs, a_req, a_bn}, {cyc == 0, vis(cyc), exp_bn});
            end
            drive_src();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = -1;
        rst_n    = 1'b0;
        src_r    = '0;
        src_g    = '0;
        src_b    = {CW{1'b1}};
        zero_px  = '0;
        test_reset();
        test_raster();
        test_pixel_data();
        test_sync_pol();
        test_default_hsync();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
